imem_loader: RTL and testbench

- Boot-time program loader. It is the writing end of the instruction_fetch load_mem port.
- Accepts a byte stream (valid/ready) carrying a word count followed by big-endian instruction words.
- Writes each assembled word into instruction memory through load_mem_en/addr/data.
- Holds the core in stall until the whole program is written, then releases it.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_word_assembler.sv | 39 +++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default instruction word width and the byte count it implies.
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned BYTES_PER_WORD = DEF_DATA_W / 8;

  // Smallest legal program length in the header byte.
  localparam int unsigned HDR_MIN = 1;

  // Bytes per instruction word for an arbitrary word width.
  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // A header is usable when it names between HDR_MIN and depth words.
  function automatic logic header_ok(input logic [7:0] n, input int unsigned depth);
    return (32'(n) >= HDR_MIN) && (32'(n) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a byte-position counter.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_out,
  output logic              word_full
);

  localparam int unsigned BPW  = bytes_per_word(DATA_W);
  localparam int          BC_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [BC_W-1:0] byte_cnt;

  // word_full flags the byte that completes the current word, so the caller
  // can act on the same edge that accepts it.
  assign word_full = byte_en && (byte_cnt == BC_W'(BPW - 1));

  // Shift accepted bytes in from the bottom; the first byte ends up in the MSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      word_out <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
      word_out <= '0;
    end else if (byte_en) begin
      word_out <= (word_out << 8) | DATA_W'(byte_in);
      byte_cnt <= word_full ? '0 : byte_cnt + BC_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed big-endian byte stream into
// instruction-memory writes and holds the core stalled until it is done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [DATA_W-1:0] load_mem_data,
  output logic              stall,
  output logic              done,
  output logic              error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int          CNT_W = ADDR_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  words_total;
  logic              accept;
  logic              hdr_good;
  logic              hdr_take;
  logic              byte_en;
  logic              word_full;
  logic              last_word;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W-1:0] full_word;

  assign accept    = in_valid && in_ready;
  assign hdr_good  = header_ok(in_data, DEPTH);
  assign hdr_take  = accept && (state == IDLE) && hdr_good;
  assign byte_en   = accept && (state == LOAD);
  assign last_word = (word_cnt + CNT_W'(1)) == words_total;

  // The write is registered on the edge that accepts the final byte, so the
  // complete word is formed here from the partial word plus the live byte.
  assign full_word = (asm_word << 8) | DATA_W'(in_data);

  word_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (hdr_take),
    .byte_en   (byte_en),
    .byte_in   (in_data),
    .word_out  (asm_word),
    .word_full (word_full)
  );

  // Next-state selection for the loader FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hdr_take) state_nxt = LOAD;
      LOAD:    if (word_full) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? DONE : LOAD;
      DONE:    if (start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and all outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      word_cnt      <= '0;
      words_total   <= '0;
      in_ready      <= 1'b0;
      load_mem_en   <= 1'b0;
      load_mem_addr <= '0;
      load_mem_data <= '0;
      stall         <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready    <= (state_nxt == IDLE) || (state_nxt == LOAD);
      load_mem_en <= (state_nxt == WRITE);
      stall       <= (state_nxt != DONE);
      done        <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            if (hdr_good) begin
              words_total <= CNT_W'(in_data);
              word_cnt    <= '0;
              error       <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_full) begin
            load_mem_addr <= word_cnt[ADDR_W-1:0];
            load_mem_data <= full_word;
          end
        end
        WRITE: word_cnt <= word_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              load_mem_en;
  logic [ADDR_W-1:0] load_mem_addr;
  logic [DATA_W-1:0] load_mem_data;
  logic              stall;
  logic              done;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  imem_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .load_mem_en   (load_mem_en),
    .load_mem_addr (load_mem_addr),
    .load_mem_data (load_mem_data),
    .stall         (stall),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (!rst && load_mem_en) begin
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("write_addr", 32'(load_mem_addr), 32'(w.addr));
        check("write_data", load_mem_data, w.data);
      end
    end
  end

  // Present a byte and return 1ns after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int unsigned waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < 4; k++) send_byte(v[31-8*k -: 8]);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    check("done_reached", 32'(done), 32'd1);
    check("done_stall", 32'(stall), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_stall", 32'(stall), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b0;

    // Reset state.
    #12;
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_en", 32'(load_mem_en), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(load_mem_addr), 32'd0);
    check("rst_data", load_mem_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_ready", 32'(in_ready), 32'd1);

    // Two-word program, exact strobe and done timing.
    expect_write(4'd0, 32'h12345678);
    expect_write(4'd1, 32'h9ABCDEF0);
    send_byte(8'h02);
    send_word(32'h12345678);
    check("ready_low_after_word", 32'(in_ready), 32'd0);
    send_word(32'h9ABCDEF0);
    in_valid = 1'b0;
    check("last_strobe", 32'(load_mem_en), 32'd1);
    check("last_strobe_not_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("A_done", 32'(done), 32'd1);
    check("A_stall", 32'(stall), 32'd0);
    check("A_en_low", 32'(load_mem_en), 32'd0);
    check("A_ready_low", 32'(in_ready), 32'd0);

    // Full-depth program.
    pulse_start();
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      b0 = 8'(i * 4);
      w  = {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
      expect_write(4'(i), w);
      send_word(w);
    end
    in_valid = 1'b0;
    wait_done(10);
    check("B_hold_addr", 32'(load_mem_addr), 32'd15);
    check("B_hold_data", load_mem_data, 32'h3C3D3E3F);
    check("B_queue_empty", 32'(exp_q.size()), 32'd0);

    // Bad headers, then a good one.
    pulse_start();
    send_byte(8'h00);
    in_valid = 1'b0;
    check("C_err_zero", 32'(error), 32'd1);
    check("C_idle_ready0", 32'(in_ready), 32'd1);
    send_byte(8'h11);
    in_valid = 1'b0;
    check("C_err_big", 32'(error), 32'd1);
    check("C_idle_ready1", 32'(in_ready), 32'd1);
    check("C_stall", 32'(stall), 32'd1);
    expect_write(4'd0, 32'hCAFEBABE);
    send_byte(8'h01);
    check("C_err_clear", 32'(error), 32'd0);
    send_word(32'hCAFEBABE);
    in_valid = 1'b0;
    wait_done(10);

    // Toggling in_valid.
    pulse_start();
    expect_write(4'd0, 32'hDEADBEEF);
    w = 32'hDEADBEEF;
    send_byte(8'h01);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8]);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_done(10);

    // Reset in the middle of a word.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("E_stall", 32'(stall), 32'd1);
    check("E_ready", 32'(in_ready), 32'd0);
    check("E_en", 32'(load_mem_en), 32'd0);
    check("E_addr", 32'(load_mem_addr), 32'd0);
    check("E_data", load_mem_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("E_release_ready", 32'(in_ready), 32'd1);
    expect_write(4'd0, 32'h01020304);
    send_byte(8'h01);
    send_word(32'h01020304);
    in_valid = 1'b0;
    wait_done(10);
    check("E_hold_data", load_mem_data, 32'h01020304);

    // Stream present while DONE: nothing is consumed.
    @(negedge clk);
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("F_ready_low", 32'(in_ready), 32'd0);
    end
    check("F_still_done", 32'(done), 32'd1);
    pulse_start();
    expect_write(4'd0, 32'hAABBCCDD);
    send_byte(8'h01);
    send_word(32'hAABBCCDD);
    in_valid = 1'b0;
    wait_done(10);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
